// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: shared FSM state type, event layout and default sizes for the DVS AER receiver
package dvs_ravens_pkg;
  localparam int DVS_ADDR_W = 10;
  localparam int DVS_SYNC_STAGES = 2;
  localparam int DVS_TS_W = 16;
  typedef enum logic [1:0] {IDLE, CAPTURE, ACK} aer_fsm_t;
  typedef struct packed {
    logic [DVS_ADDR_W-1:0] y;
    logic [DVS_ADDR_W-2:0] x;
    logic pol;
`ifdef DVS_AER_TIMESTAMP_EN
    logic [DVS_TS_W-1:0] ts;
`endif
  } dvs_event_t;
endpackage

// File: rtl/dvs_event_fifo.sv
// dvs_event_fifo: synchronous first-word-fall-through FIFO with occupancy output
module dvs_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     ready,
  output logic                     valid,
  output logic                     full,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign valid = level != '0;
  assign full = level == LW'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = valid & ready;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/dvs_aer_event_rx.sv
// dvs_aer_event_rx: 4-phase AER receiver pairing row/column words into buffered pixel events
// Optional per-event timestamp: define DVS_AER_TIMESTAMP_EN to add the ev_ts port.
module dvs_aer_event_rx
  import dvs_ravens_pkg::*;
#(
  parameter int ADDR_W = DVS_ADDR_W,
  parameter int SYNC_STAGES = DVS_SYNC_STAGES,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W = DVS_TS_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             aer,
  input  logic                          xsel,
  input  logic                          req,
  output logic                          ack,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [ADDR_W-1:0]             ev_y,
  output logic [ADDR_W-2:0]             ev_x,
  output logic                          ev_pol,
`ifdef DVS_AER_TIMESTAMP_EN
  output logic [TS_W-1:0]               ev_ts,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   orphan_cnt
);
`ifdef DVS_AER_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int ENTRY_W = 2 * ADDR_W + (TS_EN != 0 ? TS_W : 0);
  aer_fsm_t state, next;
  logic [SYNC_STAGES-1:0] sync;
  logic req_s, push, full, row_valid, xsel_r;
  logic [ADDR_W-1:0] aer_r, y_reg;
  logic [ENTRY_W-1:0] entry, head;
  assign req_s = sync[SYNC_STAGES-1];
  always_comb begin
    next = state;
    push = 1'b0;
    case (state)
      IDLE: next = req_s ? CAPTURE : IDLE;
      CAPTURE: begin
        push = xsel_r & row_valid & ~full;
        next = (xsel_r & row_valid & full) ? CAPTURE : ACK;
      end
      ACK: next = req_s ? ACK : IDLE;
      default: next = IDLE;
    endcase
  end
  // ack is registered from next-state so it rises together with the ACK state
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      state <= IDLE;
      ack <= 1'b0;
      row_valid <= 1'b0;
      orphan_cnt <= '0;
      aer_r <= '0;
      xsel_r <= 1'b0;
      y_reg <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req};
      state <= next;
      ack <= next == ACK;
      if (state == IDLE && req_s) begin
        aer_r <= aer;
        xsel_r <= xsel;
      end
      if (state == CAPTURE && !xsel_r) begin
        y_reg <= aer_r;
        row_valid <= 1'b1;
      end
      if (state == CAPTURE && xsel_r && !row_valid && orphan_cnt != 16'hFFFF)
        orphan_cnt <= orphan_cnt + 16'd1;
    end
  end
`ifdef DVS_AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk)
    ts <= rst ? '0 : ts + TS_W'(1);
  assign entry = {y_reg, aer_r, ts};
  assign {ev_y, ev_x, ev_pol, ev_ts} = head;
`else
  assign entry = {y_reg, aer_r};
  assign {ev_y, ev_x, ev_pol} = head;
`endif
  dvs_event_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(entry),
    .ready(ev_ready),
    .valid(ev_valid),
    .full(full),
    .dout(head),
    .level(fifo_level)
  );
endmodule

// File: tb/tb_dvs_aer_event_rx.sv
// tb_dvs_aer_event_rx: camera-side handshake driver with event scoreboard for dvs_aer_event_rx
module tb_dvs_aer_event_rx;
  logic clk = 1'b0, rst = 1'b1, xsel = 1'b0, req = 1'b0, ev_ready = 1'b1;
  logic [9:0] aer = '0;
  logic ack, ev_valid, ev_pol;
  logic [9:0] ev_y;
  logic [8:0] ev_x;
  logic [3:0] fifo_level;
  logic [15:0] orphan_cnt;
  logic [3:0] tb_ts;
`ifdef DVS_AER_TIMESTAMP_EN
  logic [3:0] ev_ts;
`endif
  int checks = 0, failures = 0;
  typedef struct {logic [9:0] y; logic [8:0] x; logic pol; logic [3:0] ts;} ev_t;
  typedef struct {logic [9:0] a; logic xs; int lat; int orphan;} vec_t;
  ev_t sb[$];
  logic rv_m = 1'b0;
  logic [9:0] y_m = '0;

  dvs_aer_event_rx #(.ADDR_W(10), .SYNC_STAGES(2), .FIFO_DEPTH(8), .TS_W(4)) dut (
    .clk(clk), .rst(rst), .aer(aer), .xsel(xsel), .req(req), .ack(ack),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_y(ev_y), .ev_x(ev_x), .ev_pol(ev_pol),
`ifdef DVS_AER_TIMESTAMP_EN
    .ev_ts(ev_ts),
`endif
    .fifo_level(fifo_level), .orphan_cnt(orphan_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_ts <= rst ? 4'd0 : tb_ts + 4'd1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && ev_valid && ev_ready) begin
      if (sb.size() == 0) chk("unexpected_event", 1, 0);
      else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_y", ev_y, e.y);
        chk("ev_x", ev_x, e.x);
        chk("ev_pol", ev_pol, e.pol);
`ifdef DVS_AER_TIMESTAMP_EN
        chk("ev_ts", ev_ts, e.ts);
`endif
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [9:0] a, input logic xs);
    aer = a;
    xsel = xs;
    req = 1'b1;
  endtask

  // waits for ack; once seen, the accepted word updates the camera-side model
  task automatic wait_ack(input int lim, output int lat);
    ev_t e;
    lat = 0;
    while (!ack && lat < lim) begin
      step();
      lat++;
    end
    if (ack && xsel && rv_m) begin
      e.y = y_m;
      e.x = aer[9:1];
      e.pol = aer[0];
      e.ts = tb_ts - 4'd1;
      sb.push_back(e);
    end
    if (ack && !xsel) begin
      rv_m = 1'b1;
      y_m = aer;
    end
  endtask

  task automatic release_req();
    int n = 0;
    req = 1'b0;
    while (ack && n < 20) begin
      step();
      n++;
    end
    chk("ack_drop", ack, 0);
  endtask

  task automatic send(input logic [9:0] a, input logic xs);
    int lat;
    start(a, xs);
    wait_ack(20, lat);
    chk("hs_latency", lat, 4);
    release_req();
  endtask

  initial begin
    vec_t vt[7];
    int lat;
    vt[0] = '{10'h0C7, 1'b1, 4, 1};
    vt[1] = '{10'h05A, 1'b0, 4, 1};
    vt[2] = '{10'h0C7, 1'b1, 4, 1};
    vt[3] = '{10'h010, 1'b0, 4, 1};
    vt[4] = '{10'h020, 1'b1, 4, 1};
    vt[5] = '{10'h3FF, 1'b1, 4, 1};
    vt[6] = '{10'h001, 1'b1, 4, 1};
    repeat (3) step();
    chk("rst_ack", ack, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_orphan", orphan_cnt, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      start(vt[i].a, vt[i].xs);
      wait_ack(20, lat);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      release_req();
      step();
      chk($sformatf("vec%0d_orphan", i), orphan_cnt, vt[i].orphan);
      chk($sformatf("vec%0d_level", i), fifo_level, 0);
    end
    chk("sb_drained_1", sb.size(), 0);

    ev_ready = 1'b0;
    send(10'h100, 1'b0);
    for (int i = 0; i < 8; i++) send(10'(i * 37 + 3), 1'b1);
    chk("bp_level_full", fifo_level, 8);
    start(10'h2D5, 1'b1);
    wait_ack(20, lat);
    chk("bp_ack_withheld", ack, 0);
    chk("bp_level_held", fifo_level, 8);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    wait_ack(5, lat);
    chk("bp_resume_ack", ack, 1);
    chk("bp_resume_within2", int'(lat <= 2), 1);
    chk("bp_level_end", fifo_level, 8);
    release_req();
    ev_ready = 1'b1;
    lat = 0;
    while (fifo_level != 0 && lat < 40) begin
      step();
      lat++;
    end
    chk("bp_drained_level", fifo_level, 0);
    step();
    chk("sb_drained_2", sb.size(), 0);

    ev_ready = 1'b0;
    send(10'h2AA, 1'b0);
    send(10'h011, 1'b1);
    send(10'h022, 1'b1);
    start(10'h033, 1'b1);
    wait_ack(20, lat);
    chk("pre_rst_ack", ack, 1);
    chk("pre_rst_level", fifo_level, 3);
    rst = 1'b1;
    req = 1'b0;
    step();
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_ev_valid", ev_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_orphan", orphan_cnt, 0);
    sb.delete();
    rv_m = 1'b0;
    rst = 1'b0;
    ev_ready = 1'b1;
    step();

`ifdef DVS_AER_TIMESTAMP_EN
    send(10'h0F0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      send(10'(i * 13 + 1), 1'b1);
      step();
    end
    repeat (3) step();
    chk("sb_drained_ts", sb.size(), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dvs_aer_event_rx.md
Name: dvs_aer_event_rx

Overview:
- Parametrised successor of the single-word DVS AER receiver.
- Runs the 4-phase req/ack handshake with the camera, synchronising `req` into `clk`.
- Pairs row words (`xsel`=0) with the column words that follow (`xsel`=1) into full pixel events: y, x, polarity.
- Buffers events in a FIFO toward the downstream event-processing core over a valid/ready interface, and applies backpressure to the camera by withholding `ack`.

Parameters:
- ADDR_W, 10, width of `aer` bus; must be ≥2.
- SYNC_STAGES, 2, flops in the `req` synchroniser; must be ≥2.
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2.
- TS_W, 16, timestamp width; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- aer  in  ADDR_W  AER address bus from camera.
- xsel  in  1  1 = column word, 0 = row word.
- req  in  1  camera request, asynchronous, active-high.
- ack  out  1  acknowledge to camera, registered.
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  downstream accepts head.
- ev_y  out  ADDR_W  event row.
- ev_x  out  ADDR_W-1  event column, which is `aer[ADDR_W-1:1]` of the column word.
- ev_pol  out  1  polarity, which is `aer[0]` of the column word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- orphan_cnt  out  16  saturating count of column words received with no preceding row.

Behaviour:
- Reset is synchronous, active-high, one clock, as already decided.
  - Reset values: `ack`=0, `ev_valid`=0, `fifo_level`=0, `orphan_cnt`=0.
  - Reset also clears `row_valid`, clears the synchroniser to 0, and sets the FSM to IDLE.
- `req_s` is `req` after SYNC_STAGES flops. `aer`/`xsel` are bundled data, stable while `req`=1, and are sampled only in IDLE→CAPTURE.
- FSM states: IDLE, CAPTURE, ACK.
  - IDLE: if `req_s`=1, register `aer` and `xsel` and go to CAPTURE.
  - CAPTURE, row word: load `y_reg`, set `row_valid`, go to ACK.
  - CAPTURE, column word with `row_valid`=1 and FIFO not full: push {`y_reg`, `aer[ADDR_W-1:1]`, `aer[0]`}, go to ACK.
  - CAPTURE, column word with FIFO full: stay in CAPTURE and keep `ack`=0 (backpressure). No event is ever dropped.
  - CAPTURE, column word with `row_valid`=0: discard, increment `orphan_cnt` saturating at 0xFFFF, go to ACK.
  - ACK: `ack`=1; when `req_s`=0, go to IDLE with `ack`=0 from the next cycle.
  - `ack` is a registered decode of the ACK state.
- Latency from `req` rising at the flop input to `ack`=1: SYNC_STAGES+2 cycles when not stalled.
- `row_valid` persists across events. Multiple column words reuse the same row until a new row word arrives.
- FIFO behaviour:
  - First-word-fall-through: the head is presented combinationally from storage while `ev_valid`=1.
  - Pop occurs on `ev_valid & ev_ready`.
  - Push and pop in the same cycle when not full: `fifo_level` is unchanged.
  - Full is evaluated at the start of the cycle; a pop in the same cycle does not permit the push, which retries next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Event outputs are don't-care while `ev_valid`=0.
- Reset mid-handshake: `ack` drops in the same cycle reset is sampled, and FIFO contents are lost. The camera must re-issue `req`.

Optional Feature:
- Macro: DVS_AER_TIMESTAMP_EN.
- With the macro:
  - A free-running TS_W-bit counter, reset to 0, wraps at 2^TS_W.
  - The counter value at the CAPTURE-cycle push is stored with each event.
  - Extra port: `ev_ts`  out  TS_W.
- Without the macro: no counter, no `ev_ts` port, FIFO entry width excludes the timestamp.

Decomposition:
- Package `dvs_ravens_pkg` holds:
  - `aer_fsm_t` enum {IDLE, CAPTURE, ACK}.
  - `dvs_event_t` packed struct {y, x, pol[, ts]}.
  - Default constants DVS_ADDR_W=10, DVS_SYNC_STAGES=2.
- Sub-module `dvs_event_fifo`: synchronous FWFT FIFO parametrised on DEPTH and entry width, exposing `level`.

Test Plan:
- Row 0x05A, then column 0x0C7 (x=0x063, pol=1), `ev_ready`=1 → one event y=0x05A, x=0x063, pol=1; `ack` rises SYNC_STAGES+2 cycles after each `req`; `fifo_level` returns to 0.
- Column word before any row after reset → no event, `orphan_cnt`=1, handshake completes normally.
- Row 0x010, then 3 column words → 3 events, all y=0x010, in order.
- `ev_ready`=0, FIFO_DEPTH=8, 9 column words → 8 events buffered, `fifo_level`=8, 9th `ack` withheld. Pulse `ev_ready` for 1 cycle → 9th `ack` follows within 2 cycles, `fifo_level` ends at 8.
- Assert `rst` while in ACK with 3 events queued → next cycle `ack`=0, `ev_valid`=0, `fifo_level`=0, `orphan_cnt`=0.
- With DVS_AER_TIMESTAMP_EN and TS_W=4, 20 events spaced 1 cycle apart → `ev_ts` increments and wraps 15→0.
